// File: rtl/imm_decode_pkg.sv
// Shared types for the immediate decode stage: select encodings and buffer states.
// Z-format decoding is compiled in only when IMM_DECODE_ZIMM_EN is defined.
package imm_decode_pkg;

  typedef enum logic [2:0] {
    IMM_SEL_I    = 3'b000,
    IMM_SEL_S    = 3'b001,
    IMM_SEL_B    = 3'b010,
    IMM_SEL_U    = 3'b011,
    IMM_SEL_J    = 3'b100,
    IMM_SEL_Z    = 3'b101,
    IMM_SEL_RSV6 = 3'b110,
    IMM_SEL_RSV7 = 3'b111
  } imm_sel_t;

  // Occupancy of the output register plus skid register.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  localparam int SEL_W = 3;

endpackage

// File: rtl/imm_decode_core.sv
// Combinational RV32 immediate extraction and extension to XLEN.
// Select 101 (Z) is decoded only when IMM_DECODE_ZIMM_EN is defined, otherwise it is illegal.
module imm_decode_core
  import imm_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]      instr,
  input  logic [SEL_W-1:0] sel,
  output logic [XLEN-1:0]  imm,
  output logic             err
);

  logic [31:0] imm32;
  logic        unused_opcode;

  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm32 = '0;
    err   = 1'b0;
    case (imm_sel_t'(sel))
      IMM_SEL_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_SEL_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_SEL_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_SEL_U: imm32 = {instr[31:12], 12'b0};
      IMM_SEL_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef IMM_DECODE_ZIMM_EN
      IMM_SEL_Z: imm32 = {27'b0, instr[19:15]};
`else
      IMM_SEL_Z: err = 1'b1;
`endif
      default:   err = 1'b1;
    endcase
  end

  // Bit 31 of imm32 already carries the format sign (and is 0 for Z), so widening replicates it.
  generate
    if (XLEN > 32) begin : g_wide
      assign imm = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_narrow
      assign imm = imm32[XLEN-1:0];
    end
  endgenerate

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: decode core followed by a two-entry (output + skid) valid/ready buffer.
// Optional Z-format decode is enabled with IMM_DECODE_ZIMM_EN.
module imm_decode_stage
  import imm_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [31:0]      instr_i,
  input  logic [2:0]       imm_sel_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       sel_o,
  output logic             err_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // ready_o comes only from registered state, and flush_i blocks both transfers that cycle.

  buf_state_t      state_q, state_d;
  logic            accept, retire;
  logic            load_out_dec, load_out_skid, load_skid;
  logic [XLEN-1:0] dec_imm;
  logic            dec_err;
  logic [XLEN-1:0] out_imm_q, skid_imm_q;
  logic [2:0]      out_sel_q, skid_sel_q;
  logic            out_err_q, skid_err_q;

  imm_decode_core #(.XLEN(XLEN)) u_core (
    .instr (instr_i),
    .sel   (imm_sel_i),
    .imm   (dec_imm),
    .err   (dec_err)
  );

  assign accept = valid_i & (state_q != BUF_TWO) & ~flush_i;
  assign retire = ready_i & (state_q != BUF_EMPTY) & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BUF_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: if (accept) state_d = BUF_ONE;
        BUF_ONE: begin
          if (accept && !retire)      state_d = BUF_TWO;
          else if (retire && !accept) state_d = BUF_EMPTY;
        end
        BUF_TWO:   if (retire) state_d = BUF_ONE;
        default:   state_d = BUF_EMPTY;
      endcase
    end
  end

  always_comb begin
    ready_o = (state_q != BUF_TWO);
    valid_o = (state_q != BUF_EMPTY);
    imm_o   = out_imm_q;
    sel_o   = out_sel_q;
    err_o   = out_err_q;
  end

  // New data goes straight to the output register unless it would overtake a held entry.
  assign load_out_dec  = accept & ((state_q == BUF_EMPTY) | retire);
  assign load_skid     = accept & (state_q == BUF_ONE) & ~retire;
  assign load_out_skid = retire & (state_q == BUF_TWO);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_imm_q  <= '0;
      out_sel_q  <= '0;
      out_err_q  <= 1'b0;
      skid_imm_q <= '0;
      skid_sel_q <= '0;
      skid_err_q <= 1'b0;
    end else begin
      if (load_out_dec) begin
        out_imm_q <= dec_imm;
        out_sel_q <= imm_sel_i;
        out_err_q <= dec_err;
      end else if (load_out_skid) begin
        out_imm_q <= skid_imm_q;
        out_sel_q <= skid_sel_q;
        out_err_q <= skid_err_q;
      end
      if (load_skid) begin
        skid_imm_q <= dec_imm;
        skid_sel_q <= imm_sel_i;
        skid_err_q <= dec_err;
      end
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances in lockstep against a queue-based model.
// Define IMM_DECODE_ZIMM_EN for both RTL and bench to exercise Z-format decoding.
module tb_imm_decode_stage;

  localparam int EW = 68;  // {err, sel[2:0], imm[63:0]}

  logic        clk = 1'b0;
  logic        rst_i, valid_i, flush_i, ready_i;
  logic [31:0] instr_i;
  logic [2:0]  imm_sel_i;

  logic        ready_o_32, valid_o_32, err_o_32;
  logic [31:0] imm_o_32;
  logic [2:0]  sel_o_32;
  logic        ready_o_64, valid_o_64, err_o_64;
  logic [63:0] imm_o_64;
  logic [2:0]  sel_o_64;

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];
  bit zimm_en;

  imm_decode_stage #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o_32),
    .instr_i(instr_i), .imm_sel_i(imm_sel_i), .flush_i(flush_i),
    .valid_o(valid_o_32), .ready_i(ready_i), .imm_o(imm_o_32),
    .sel_o(sel_o_32), .err_o(err_o_32)
  );

  imm_decode_stage #(.XLEN(64)) dut64 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o_64),
    .instr_i(instr_i), .imm_sel_i(imm_sel_i), .flush_i(flush_i),
    .valid_o(valid_o_64), .ready_i(ready_i), .imm_o(imm_o_64),
    .sel_o(sel_o_64), .err_o(err_o_64)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference decode by field arithmetic: returns {err, imm64}.
  function automatic logic [64:0] ref_model(input logic [31:0] ins, input logic [2:0] sel);
    longint v;
    logic   err;
    v   = 0;
    err = 1'b0;
    case (sel)
      3'd0: begin v = ins[31:20]; if (ins[31]) v -= 64'sd4096; end
      3'd1: begin v = {ins[31:25], ins[11:7]}; if (ins[31]) v -= 64'sd4096; end
      3'd2: begin v = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; if (ins[31]) v -= 64'sd8192; end
      3'd3: begin v = longint'(ins[31:12]) * 64'sd4096; if (ins[31]) v -= 64'sd4294967296; end
      3'd4: begin v = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; if (ins[31]) v -= 64'sd2097152; end
      3'd5: begin if (zimm_en) v = ins[19:15]; else err = 1'b1; end
      default: err = 1'b1;
    endcase
    return {err, 64'(v)};
  endfunction

  // Called at a falling edge: check outputs, drive inputs, update the model, advance one cycle.
  task automatic step(input logic v, input logic [31:0] ins, input logic [2:0] sel,
                      input logic rdy, input logic fl, input logic [64:0] exp_ei,
                      output logic acc);
    logic [EW-1:0] front;
    logic          ret;
    check("ready_o32", ready_o_32, exp_q.size() < 2);
    check("ready_o64", ready_o_64, exp_q.size() < 2);
    check("valid_o32", valid_o_32, exp_q.size() != 0);
    check("valid_o64", valid_o_64, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      front = exp_q[0];
      check("imm_o32", imm_o_32, front[31:0]);
      check("imm_o64", imm_o_64, front[63:0]);
      check("sel_o32", sel_o_32, front[66:64]);
      check("sel_o64", sel_o_64, front[66:64]);
      check("err_o32", err_o_32, front[67]);
      check("err_o64", err_o_64, front[67]);
    end
    valid_i   = v;
    instr_i   = ins;
    imm_sel_i = sel;
    ready_i   = rdy;
    flush_i   = fl;
    acc = v && (exp_q.size() < 2) && !fl;
    ret = (exp_q.size() != 0) && rdy && !fl;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (ret) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({exp_ei[64], sel, exp_ei[63:0]});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] ins, input logic [2:0] sel,
                      input logic [64:0] exp_ei, input logic rdy);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) step(1'b1, ins, sel, rdy, 1'b0, exp_ei, acc);
    if (!acc) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(1'b0, 32'd0, 3'd0, 1'b1, 1'b0, 65'd0, acc);
    if (exp_q.size() != 0) check("drain_timeout", 64'd0, 64'd1);
    step(1'b0, 32'd0, 3'd0, 1'b1, 1'b0, 65'd0, acc);
  endtask

  // Reset asserted with valid/flush/ready active to confirm reset priority and discard.
  task automatic do_reset();
    rst_i     = 1'b1;
    valid_i   = 1'b1;
    instr_i   = $urandom;
    imm_sel_i = 3'd0;
    ready_i   = 1'b1;
    flush_i   = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_i   = 1'b0;
    valid_i = 1'b0;
    flush_i = 1'b0;
    exp_q.delete();
    check("rst_valid_o32", valid_o_32, 64'd0);
    check("rst_valid_o64", valid_o_64, 64'd0);
    check("rst_ready_o32", ready_o_32, 64'd1);
    check("rst_imm_o32", imm_o_32, 64'd0);
    check("rst_imm_o64", imm_o_64, 64'd0);
    check("rst_sel_o32", sel_o_32, 64'd0);
    check("rst_err_o32", err_o_32, 64'd0);
  endtask

  initial begin
    logic        acc;
    logic [31:0] p_ins;
    logic [2:0]  p_sel;
`ifdef IMM_DECODE_ZIMM_EN
    zimm_en = 1'b1;
`else
    zimm_en = 1'b0;
`endif
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
    instr_i = '0; imm_sel_i = '0;
    do_reset();

    // Single formats with known results.
    send(32'hFFF00093, 3'd0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b1);
    send(32'h0020A423, 3'd1, {1'b0, 64'h0000_0000_0000_0008}, 1'b1);
    send(32'hFE000EE3, 3'd2, {1'b0, 64'hFFFF_FFFF_FFFF_FFFC}, 1'b1);
    send(32'h123450B7, 3'd3, {1'b0, 64'h0000_0000_1234_5000}, 1'b1);
    send(32'h800000B7, 3'd3, {1'b0, 64'hFFFF_FFFF_8000_0000}, 1'b1);
    send(32'h8000006F, 3'd4, {1'b0, 64'hFFFF_FFFF_FFF0_0000}, 1'b1);
    send(32'h12345678, 3'd7, {1'b1, 64'h0}, 1'b1);
    send(32'hFFFFFFFF, 3'd6, {1'b1, 64'h0}, 1'b1);
    // instr[19:15] of 0x0000D073 is 1; 0x000DD073 carries 27 there.
`ifdef IMM_DECODE_ZIMM_EN
    send(32'h0000D073, 3'd5, {1'b0, 64'h1}, 1'b1);
    send(32'h000DD073, 3'd5, {1'b0, 64'h1B}, 1'b1);
`else
    send(32'h0000D073, 3'd5, {1'b1, 64'h0}, 1'b1);
    send(32'h000DD073, 3'd5, {1'b1, 64'h0}, 1'b1);
`endif
    drain();

    // Backpressure: three back-to-back with ready_i low; third is held until space frees.
    step(1'b1, 32'h00100093, 3'd0, 1'b0, 1'b0, {1'b0, 64'h1}, acc);
    check("bp_acc_a", acc, 64'd1);
    step(1'b1, 32'h00200093, 3'd0, 1'b0, 1'b0, {1'b0, 64'h2}, acc);
    check("bp_acc_b", acc, 64'd1);
    step(1'b1, 32'h00300093, 3'd0, 1'b0, 1'b0, {1'b0, 64'h3}, acc);
    check("bp_acc_c", acc, 64'd0);
    step(1'b1, 32'h00300093, 3'd0, 1'b0, 1'b0, {1'b0, 64'h3}, acc);
    send(32'h00300093, 3'd0, {1'b0, 64'h3}, 1'b1);
    drain();

    // Flush in TWO with a same-cycle input; nothing may emerge afterwards.
    step(1'b1, 32'h00400093, 3'd0, 1'b0, 1'b0, {1'b0, 64'h4}, acc);
    step(1'b1, 32'h00500093, 3'd0, 1'b0, 1'b0, {1'b0, 64'h5}, acc);
    step(1'b1, 32'h00600093, 3'd0, 1'b1, 1'b1, {1'b0, 64'h6}, acc);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 3'd0, 1'b1, 1'b0, 65'd0, acc);

    // Random traffic with an upstream that holds each item until accepted.
    p_ins = $urandom;
    p_sel = 3'($urandom_range(0, 7));
    for (int i = 0; i < 500; i++) begin
      if (i == 250) begin
        do_reset();
      end
      step(1'($urandom_range(0, 3) != 0), p_ins, p_sel, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 24) == 0), ref_model(p_ins, p_sel), acc);
      if (acc) begin
        p_ins = $urandom;
        p_sel = 3'($urandom_range(0, 7));
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
